// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin packet arbiter locking one of four requesters onto a registered output
module output_port_arbiter #(
  parameter int WIDTH = 8,
  localparam int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ-1:0]       in_last,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [1:0]            win,
  output logic                  busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [1:0] ptr, grant;
  logic xfer, xlast;
  logic [WIDTH-1:0] xdata;
  // first requester at or above ptr, wrapping; scanning downward lets the nearest one win
  always_comb begin
    grant = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (in_valid[2'(ptr + 2'(k))]) grant = 2'(ptr + 2'(k));
  end
  assign in_ready = (state == LOCKED && (!out_valid || out_ready)) ? 4'b0001 << win : '0;
  assign xfer     = |(in_valid & in_ready);
  assign xlast    = in_last[win];
  assign xdata    = in_data[win*WIDTH +: WIDTH];
  // arbitration FSM and output register; data/last hold after the flit drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_last  <= xlast;
        out_data  <= xdata;
      end else if (out_ready) out_valid <= 1'b0;
      if (state == IDLE && |in_valid) begin
        state <= LOCKED;
        busy  <= 1'b1;
        win   <= grant;
      end else if (state == LOCKED && xfer && xlast) begin
        state <= IDLE;
        busy  <= 1'b0;
        ptr   <= win + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: table-driven cycle vectors with a flit scoreboard for output_port_arbiter
module tb_output_port_arbiter;
  localparam int W = 16;
  typedef struct {
    bit          rst;
    logic [3:0]  v, l;
    logic [63:0] d;
    bit          o;
    logic [3:0]  rdy;
    bit          b;
    logic [1:0]  w;
    bit          ov;
  } vec_t;
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } flit_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = '0, in_last = '0, in_ready;
  logic [4*W-1:0] in_data = '0;
  logic         out_valid, out_last, out_ready = 1'b1, busy;
  logic [W-1:0] out_data;
  logic [1:0]   win;
  int           tests = 0, fails = 0;
  vec_t         tv[$];
  flit_t        q[$];

  output_port_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready), .win(win), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(bit rst, logic [3:0] v, logic [3:0] l, logic [63:0] d, bit o,
                     logic [3:0] rdy, bit b, logic [1:0] w, bit ov);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d = d; r.o = o;
    r.rdy = rdy; r.b = b; r.w = w; r.ov = ov;
    tv.push_back(r);
  endtask

  // asynchronous reset pulse placed mid-cycle, well away from any clock edge
  task automatic do_reset(int n);
    rst_n = 1'b0;
    #1;
    chk($sformatf("rst%0d_out_valid", n), 64'(out_valid), 64'd0);
    chk($sformatf("rst%0d_busy", n), 64'(busy), 64'd0);
    chk($sformatf("rst%0d_win", n), 64'(win), 64'd0);
    chk($sformatf("rst%0d_in_ready", n), 64'(in_ready), 64'd0);
    chk($sformatf("rst%0d_out_data", n), 64'(out_data), 64'd0);
    chk($sformatf("rst%0d_out_last", n), 64'(out_last), 64'd0);
    #1 rst_n = 1'b1;
    q.delete();
  endtask

  initial begin
    // two 2-flit packets from requesters 1 and 2, one idle input cycle between them
    add(1, 4'b0110, 4'b0000, 64'h0000_00B1_00A1_0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0110, 4'b0000, 64'h0000_00B1_00A1_0000, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b0110, 4'b0010, 64'h0000_00B1_00A2_0000, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0100, 4'b0000, 64'h0000_00B1_0000_0000, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b0100, 4'b0000, 64'h0000_00B1_0000_0000, 1, 4'b0100, 1, 2, 0);
    add(0, 4'b0100, 4'b0100, 64'h0000_00B2_0000_0000, 1, 4'b0100, 1, 2, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 2, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 2, 0);
    // all four requesting single-flit packets: rotation 0,1,2,3,0
    add(1, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0100, 1, 2, 0);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0000, 0, 2, 1);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b1000, 1, 3, 0);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0000, 0, 3, 1);
    add(0, 4'b1111, 4'b1111, 64'h00C3_00C2_00C1_00C0, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 0);
    // downstream stall for three cycles while locked
    add(1, 4'b0001, 4'b0000, 64'h0000_0000_0000_00D1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 64'h0000_0000_0000_00D1, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00D2, 0, 4'b0000, 1, 0, 1);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00D2, 0, 4'b0000, 1, 0, 1);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00D2, 0, 4'b0000, 1, 0, 1);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00D2, 1, 4'b0001, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 0);
    // winner 2 drops valid mid-packet while requester 0 waits
    add(1, 4'b0100, 4'b0000, 64'h0000_00E1_0000_0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0101, 4'b0001, 64'h0000_00E1_0000_00F1, 1, 4'b0100, 1, 2, 0);
    add(0, 4'b0001, 4'b0001, 64'h0000_00E1_0000_00F1, 1, 4'b0100, 1, 2, 1);
    add(0, 4'b0101, 4'b0001, 64'h0000_00E2_0000_00F1, 1, 4'b0100, 1, 2, 0);
    add(0, 4'b0101, 4'b0101, 64'h0000_00E3_0000_00F1, 1, 4'b0100, 1, 2, 1);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00F1, 1, 4'b0000, 0, 2, 1);
    add(0, 4'b0001, 4'b0001, 64'h0000_0000_0000_00F1, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 0);
    // reset mid-packet with win=3, then lowest requester wins from ptr=0
    add(1, 4'b1000, 4'b0000, 64'h0A31_0000_0000_0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 4'b0000, 64'h0A31_0000_0000_0000, 1, 4'b1000, 1, 3, 0);
    add(0, 4'b1000, 4'b0000, 64'h0A32_0000_0000_0000, 1, 4'b1000, 1, 3, 1);
    add(1, 4'b0110, 4'b0110, 64'h0000_00C2_00C1_0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0110, 4'b0110, 64'h0000_00C2_00C1_0000, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 1, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 1, 0);
    // requester 3 single flit 0xBEEF, ptr wraps so requester 0 beats 3 next
    add(1, 4'b1000, 4'b1000, 64'hBEEF_0000_0000_0000, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 4'b1000, 64'hBEEF_0000_0000_0000, 1, 4'b1000, 1, 3, 0);
    add(0, 4'b1001, 4'b1001, 64'h0BAD_0000_0000_00D0, 1, 4'b0000, 0, 3, 1);
    add(0, 4'b1001, 4'b1001, 64'h0BAD_0000_0000_00D0, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 0);

    for (int n = 0; n < tv.size(); n++) begin
      vec_t r;
      r = tv[n];
      @(negedge clk);
      if (r.rst) do_reset(n);
      in_valid  = r.v;
      in_last   = r.l;
      in_data   = r.d;
      out_ready = r.o;
      #1;
      chk($sformatf("row%0d_in_ready", n), 64'(in_ready), 64'(r.rdy));
      chk($sformatf("row%0d_busy", n), 64'(busy), 64'(r.b));
      chk($sformatf("row%0d_win", n), 64'(win), 64'(r.w));
      chk($sformatf("row%0d_out_valid", n), 64'(out_valid), 64'(r.ov));
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL row%0d_scoreboard: got flit %h with nothing expected", n, out_data);
        end else begin
          chk($sformatf("row%0d_out_data", n), 64'(out_data), 64'(q[0].d));
          chk($sformatf("row%0d_out_last", n), 64'(out_last), 64'(q[0].l));
          if (out_ready) void'(q.pop_front());
        end
      end
      for (int i = 0; i < 4; i++)
        if (r.v[i] && r.rdy[i]) begin
          flit_t f;
          f.d = r.d[i*W +: W];
          f.l = r.l[i];
          q.push_back(f);
        end
    end
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
